pi_uart_rx: RTL and testbench

- Asynchronous serial (8N1 UART) receiver on the Raspberry Pi GPIO21 link (FPGA pin D3).
- Upstream of the display path: recovers bytes sent by the Pi and presents a held 8-bit value.
- The held value drives the seg and LED outputs in place of the free-running counter value.
- Runs on the 50 MHz board clock; rx is a raw, asynchronous pin input.

---
 rtl/pi_uart_rx.sv | 77 +++++++
 tb/tb_pi_uart_rx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pi_uart_rx.sv
// pi_uart_rx: 8N1 UART receiver for the Pi GPIO21 link; holds the last good byte.
module pi_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int H = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] H_END = CW'(H - 1);
    localparam logic [CW-1:0] B_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, WAIT_IDLE = 3'd4;
    logic          rx_m, rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitidx;
    logic [7:0]    shreg;
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bitidx    <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: if (cnt == H_END) begin
                    cnt    <= '0;
                    bitidx <= '0;
                    state  <= rx_s ? IDLE : DATA;
                end
                DATA: if (cnt == B_END) begin
                    cnt    <= '0;
                    shreg  <= {rx_s, shreg[7:1]};
                    bitidx <= bitidx + 1'b1;
                    if (bitidx == 3'd7) state <= STOP;
                end
                STOP: if (cnt == B_END) begin
                    cnt <= '0;
                    // IDLE is re-entered mid stop bit so a following start edge is caught
                    if (rx_s) begin
                        data  <= shreg;
                        valid <= 1'b1;
                        state <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pi_uart_rx.sv
// tb_pi_uart_rx: directed checks of pi_uart_rx framing, glitch, error and reset handling.
module tb_pi_uart_rx;
    localparam int N = 16;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;
    int checks = 0, failures = 0;
    int cyc = 0;
    int vcnt = 0, fcnt = 0, bcnt = 0, both = 0, longp = 0;
    logic pv = 1'b0, pf = 1'b0;
    logic [7:0] vd[$];
    int vc[$];

    pi_uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data),
        .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            vd.push_back(data);
            vc.push_back(cyc);
        end
        if (frame_err) fcnt++;
        if (busy) bcnt++;
        if (valid && frame_err) both++;
        if ((valid && pv) || (frame_err && pf)) longp++;
        pv = valid;
        pf = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        idle(N);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
        rx = 1'b1;
    endtask

    int c, v0, f0, b0, k;

    initial begin
        idle(5);
        rst = 1'b0;
        idle(1);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        idle(200);
        check("idle_valid_cnt", vcnt, 0);
        check("idle_ferr_cnt", fcnt, 0);
        check("idle_busy_cnt", bcnt, 0);

        // single byte, timing: 2 sync + 1 detect + H + 9N cycles after the start edge
        v0 = vcnt; f0 = fcnt; c = cyc;
        send_frame(8'hA5, 1'b1);
        idle(5);
        check("a5_valid_cnt", vcnt - v0, 1);
        check("a5_data", data, 8'hA5);
        check("a5_latency", vc[vc.size()-1] - c, 3 + N/2 + 9*N);
        check("a5_ferr_cnt", fcnt - f0, 0);
        check("a5_busy_after", busy, 0);

        // glitch shorter than half a bit
        v0 = vcnt; f0 = fcnt; b0 = bcnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        check("glitch_busy_cycles", bcnt - b0, N/2);
        check("glitch_valid_cnt", vcnt - v0, 0);
        check("glitch_ferr_cnt", fcnt - f0, 0);
        check("glitch_data", data, 8'hA5);
        check("glitch_busy_after", busy, 0);

        // framing error: line stays low for 3 bit times after the data bits
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        idle(2*N);
        check("ferr_cnt", fcnt - f0, 1);
        check("ferr_valid_cnt", vcnt - v0, 0);
        check("ferr_data", data, 8'hA5);
        check("ferr_busy_held", busy, 1);
        rx = 1'b1;
        idle(5);
        check("ferr_busy_release", busy, 0);
        idle(2*N);
        v0 = vcnt;
        send_frame(8'h01, 1'b1);
        idle(5);
        check("post_ferr_valid_cnt", vcnt - v0, 1);
        check("post_ferr_data", data, 8'h01);

        // back-to-back frames with a single stop bit
        idle(N);
        v0 = vcnt; k = vd.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(5);
        check("b2b_valid_cnt", vcnt - v0, 2);
        if (vd.size() >= k + 2) begin
            check("b2b_data0", vd[k], 8'h00);
            check("b2b_data1", vd[k+1], 8'hFF);
            check("b2b_spacing", vc[k+1] - vc[k], 10*N);
        end
        check("b2b_data_final", data, 8'hFF);

        // reset during bit 4 of 0x5A
        v0 = vcnt;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(((8'h5A >> i) & 8'h01) != 0);
        rx = 1'b1;
        idle(N/2);
        rst = 1'b1;
        idle(3);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        idle(3*N);
        check("mid_rst_valid_cnt", vcnt - v0, 0);
        check("mid_rst_data_hold", data, 8'h00);
        send_frame(8'h81, 1'b1);
        idle(5);
        check("post_rst_valid_cnt", vcnt - v0, 1);
        check("post_rst_data", data, 8'h81);

        check("pulse_overlap", both, 0);
        check("pulse_width", longp, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
